// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side control and status stage of a synchronous FIFO.
// Produces the memory write strobe and write pointer, and tracks occupancy.
// From occupancy it decodes the empty/full and almost-threshold flags.
// Optional sticky overflow/underflow error flags are compiled in when the
// macro FIFO_WR_ERR_EN is defined; otherwise both error outputs are tied to 0.
module fifo_wr_ctrl #(
    parameter int MEM_SIZE = 8,
    parameter int PTR_L    = 3,
    parameter int AF_TH    = 6,
    parameter int AE_TH    = 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             fifo_wr,
    input  logic             fifo_rd,
    input  logic             err_clr,
    output logic             push,
    output logic [PTR_L-1:0] wr_ptr,
    output logic [PTR_L:0]   count,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam logic [PTR_L:0]   C_MEM  = MEM_SIZE[PTR_L:0];
    localparam logic [PTR_L:0]   C_AF   = AF_TH[PTR_L:0];
    localparam logic [PTR_L:0]   C_AE   = AE_TH[PTR_L:0];
    localparam logic [PTR_L-1:0] C_LAST = PTR_L'(MEM_SIZE - 1);

    logic [PTR_L-1:0] r_wr_ptr;
    logic [PTR_L:0]   r_count;
    logic             w_pop;
    logic             w_push;

    // The pop rule copies the read side's rule. It looks at fifo_wr, not at
    // push, so push -> pop -> push never forms a combinational loop.
    assign w_pop  = !reset_L && fifo_rd && (!fifo_empty || fifo_wr);
    assign w_push = !reset_L && fifo_wr && (!fifo_full || w_pop);

    // Write pointer: advance on push, wrap at MEM_SIZE-1 even for a depth
    // that is not a power of two.
    always_ff @(posedge clk) begin
        if (reset_L)
            r_wr_ptr <= '0;
        else if (w_push)
            r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
    end

    // Occupancy: the push/pop rules keep it inside 0..MEM_SIZE.
    always_ff @(posedge clk) begin
        if (reset_L)
            r_count <= '0;
        else if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
        else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
    end

    assign push         = w_push;
    assign wr_ptr       = r_wr_ptr;
    assign count        = r_count;
    assign fifo_empty   = (r_count == '0);
    assign fifo_full    = (r_count == C_MEM);
    assign almost_full  = (r_count >= C_AF);
    assign almost_empty = (r_count <= C_AE);

`ifdef FIFO_WR_ERR_EN
    logic r_ovf;
    logic r_unf;

    // Sticky error flags: a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (reset_L) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (fifo_wr && !w_push)
                r_ovf <= 1'b1;
            else if (err_clr)
                r_ovf <= 1'b0;
            if (fifo_rd && !w_pop)
                r_unf <= 1'b1;
            else if (err_clr)
                r_unf <= 1'b0;
        end
    end

    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;
`else
    // Without error tracking the clear input has no function.
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign overflow_err     = 1'b0;
    assign underflow_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: a depth-8 instance covers the main
// behaviour, and a depth-6 instance covers non-power-of-two pointer wrap.
module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_L, fifo_wr, fifo_rd, err_clr;
    logic       push, fifo_empty, fifo_full, almost_full, almost_empty;
    logic       overflow_err, underflow_err;
    logic [2:0] wr_ptr;
    logic [3:0] count;

    logic       b_rst, b_wr, b_rd;
    logic       b_push, b_empty, b_full, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_ptr;
    logic [3:0] b_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_wr_ctrl #(.MEM_SIZE(8), .PTR_L(3), .AF_TH(6), .AE_TH(1)) dut (
        .clk(clk), .reset_L(reset_L), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
        .err_clr(err_clr), .push(push), .wr_ptr(wr_ptr), .count(count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    fifo_wr_ctrl #(.MEM_SIZE(6), .PTR_L(3), .AF_TH(5), .AE_TH(0)) dut6 (
        .clk(clk), .reset_L(b_rst), .fifo_wr(b_wr), .fifo_rd(b_rd),
        .err_clr(1'b0), .push(b_push), .wr_ptr(b_ptr), .count(b_count),
        .fifo_empty(b_empty), .fifo_full(b_full),
        .almost_full(b_af), .almost_empty(b_ae),
        .overflow_err(b_ovf), .underflow_err(b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; outputs settle 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_L = 1'b1; fifo_wr = 1'b0; fifo_rd = 1'b0; err_clr = 1'b0;
        b_rst = 1'b1; b_wr = 1'b0; b_rd = 1'b0;
        tick(); tick();

        // Reset state, with a write request present that must be ignored
        fifo_wr = 1'b1; #1;
        chk("rst_push", push, 0);
        chk("rst_count", count, 0);
        chk("rst_ptr", wr_ptr, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_unf", underflow_err, 0);
        tick();
        chk("rst_hold_count", count, 0);
        reset_L = 1'b0; fifo_wr = 1'b0;

        // Fill with 8 writes
        for (int i = 0; i < 8; i++) begin
            fifo_wr = 1'b1; #1;
            chk("fill_push", push, 1);
            chk("fill_ptr", wr_ptr, i);
            tick();
            chk("fill_count", count, i + 1);
            chk("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
            chk("fill_full", fifo_full, (i + 1 == 8) ? 1 : 0);
            chk("fill_ae", almost_empty, (i + 1 <= 1) ? 1 : 0);
        end
        fifo_wr = 1'b0;
        chk("fill_ptr_wrap", wr_ptr, 0);

        // Write while full: refused
        fifo_wr = 1'b1; #1;
        chk("ovf_push", push, 0);
        tick();
        fifo_wr = 1'b0;
        chk("ovf_count", count, 8);
        chk("ovf_ptr", wr_ptr, 0);
        chk("ovf_flag", overflow_err, ERR);
        tick();
        chk("ovf_sticky", overflow_err, ERR);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", overflow_err, 0);

        // Full with simultaneous read and write
        fifo_rd = 1'b1; fifo_wr = 1'b1; #1;
        chk("fullrw_push", push, 1);
        tick();
        chk("fullrw_count", count, 8);
        chk("fullrw_ptr", wr_ptr, 1);
        chk("fullrw_ovf", overflow_err, 0);
        chk("fullrw_unf", underflow_err, 0);

        // Drain with reads only
        fifo_wr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("drain_count", count, 8 - k);
            chk("drain_empty", fifo_empty, (k == 8) ? 1 : 0);
            chk("drain_ae", almost_empty, (8 - k <= 1) ? 1 : 0);
        end
        chk("drain_ptr", wr_ptr, 1);
        fifo_rd = 1'b0;

        // Empty pass-through: read and write together
        fifo_rd = 1'b1; fifo_wr = 1'b1; #1;
        chk("pass_push", push, 1);
        tick();
        fifo_rd = 1'b0; fifo_wr = 1'b0;
        chk("pass_count", count, 0);
        chk("pass_empty", fifo_empty, 1);
        chk("pass_ptr", wr_ptr, 2);
        chk("pass_unf", underflow_err, 0);

        // Read while empty: refused
        fifo_rd = 1'b1;
        tick();
        chk("unf_count", count, 0);
        chk("unf_flag", underflow_err, ERR);
        err_clr = 1'b1;
        tick();
        chk("unf_setwins", underflow_err, ERR);
        fifo_rd = 1'b0;
        tick();
        err_clr = 1'b0;
        chk("unf_clr", underflow_err, 0);

        // Leave an underflow pending, then fill to 5 and reset mid-operation
        fifo_rd = 1'b1;
        tick();
        fifo_rd = 1'b0;
        chk("pre_unf", underflow_err, ERR);
        fifo_wr = 1'b1;
        repeat (5) tick();
        fifo_wr = 1'b0;
        chk("mid_count", count, 5);
        chk("mid_ptr", wr_ptr, 7);
        reset_L = 1'b1; fifo_wr = 1'b1; #1;
        chk("mid_rst_push", push, 0);
        tick();
        reset_L = 1'b0; fifo_wr = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ptr", wr_ptr, 0);
        chk("mid_rst_empty", fifo_empty, 1);
        chk("mid_rst_unf", underflow_err, 0);
        chk("mid_rst_ovf", overflow_err, 0);

        // Depth-6 instance: pointer wraps 5 -> 0
        b_rst = 1'b0; b_wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("d6_ptr", b_ptr, i);
            tick();
        end
        chk("d6_ptr_wrap", b_ptr, 0);
        chk("d6_full", b_full, 1);
        chk("d6_af", b_af, 1);
        b_rd = 1'b1; #1;
        chk("d6_rw_push", b_push, 1);
        tick();
        b_wr = 1'b0; b_rd = 1'b0;
        chk("d6_rw_ptr", b_ptr, 1);
        chk("d6_rw_count", b_count, 6);
        chk("d6_ovf", b_ovf, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
